truth_table_sweep_ctrl: RTL and testbench

Sequencer that characterises one evolved combinational circuit under test (CUT), such as an LCELL-based candidate with a 4-bit input and a 1-bit output. It drives every input vector onto the CUT, waits a fixed settle time, and samples the asynchronous CUT output several times to detect oscillation. It then builds the observed truth table and scores it against a target table. It sits between the test harness (start/done/results) and the CUT instance.

---
 rtl/truth_table_sweep_ctrl_if.sv | 35 +++
 rtl/truth_table_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_truth_table_sweep_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// truth_table_sweep_ctrl_if
// Bundles the harness handshake, the CUT drive/return pair and the result
// bus of truth_table_sweep_ctrl.
//   start         : sweep request (harness -> controller)
//   cut_in        : vector applied to the CUT (controller -> CUT)
//   cut_out       : raw asynchronous CUT output (CUT -> controller)
//   busy / done   : sweep status (controller -> harness)
//   result_tt     : first observed sample per vector
//   unstable_mask : vectors whose samples disagreed
//   score         : stable vectors matching the target table
// Modports: master = harness + CUT side, slave = controller side.
// ---------------------------------------------------------------------------
interface truth_table_sweep_ctrl_if #(
    parameter int unsigned IN_WIDTH = 4
);
    logic                       start;
    logic [IN_WIDTH-1:0]        cut_in;
    logic                       cut_out;
    logic                       busy;
    logic                       done;
    logic [(2**IN_WIDTH)-1:0]   result_tt;
    logic [(2**IN_WIDTH)-1:0]   unstable_mask;
    logic [IN_WIDTH:0]          score;

    modport master (
        output start, cut_out,
        input  cut_in, busy, done, result_tt, unstable_mask, score
    );

    modport slave (
        input  start, cut_out,
        output cut_in, busy, done, result_tt, unstable_mask, score
    );
endinterface

// File: rtl/truth_table_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// truth_table_sweep_ctrl
// Sweeps every input vector of a combinational circuit under test, waits a
// settle time, samples the synchronised CUT output NUM_SAMPLES times, and
// builds the observed truth table, an instability mask and a match score
// against TARGET.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : truth_table_sweep_ctrl_if.slave (start, cut_in, cut_out, busy,
//           done, result_tt, unstable_mask, score)
// Build option: define SWEEP_GRAY_EN to apply vectors in Gray-code order;
// results remain indexed by the actual input value.
// ---------------------------------------------------------------------------
module truth_table_sweep_ctrl #(
    parameter int unsigned              IN_WIDTH      = 4,
    parameter int unsigned              SETTLE_CYCLES = 8,
    parameter int unsigned              NUM_SAMPLES   = 4,
    parameter logic [(2**IN_WIDTH)-1:0] TARGET        = '0
) (
    input logic                     clk,
    input logic                     reset,
    truth_table_sweep_ctrl_if.slave bus
);
    localparam int unsigned NV      = 2 ** IN_WIDTH;
    localparam int unsigned SW      = IN_WIDTH + 1;
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > NUM_SAMPLES) ? SETTLE_CYCLES : NUM_SAMPLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    if (SETTLE_CYCLES < 3) begin : g_chk_settle
        $error("SETTLE_CYCLES must be at least 3");
    end
    if (NUM_SAMPLES < 2) begin : g_chk_samples
        $error("NUM_SAMPLES must be at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [IN_WIDTH-1:0] r_idx;
    logic [IN_WIDTH-1:0] r_cut_in;
    logic                r_sync1, r_sync2;
    logic [NV-1:0]       r_tt, r_unst;
    logic [SW-1:0]       r_score;
    logic [NV-1:0]       w_tt_nxt, w_unst_nxt, w_match;
    logic [SW-1:0]       w_score;
    logic                w_settle_last, w_sample_last, w_final_vec;
    logic                w_busy, w_done;

    // Sweep step -> applied vector.
    function automatic logic [IN_WIDTH-1:0] vec_of(input logic [IN_WIDTH-1:0] idx);
`ifdef SWEEP_GRAY_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    assign w_settle_last = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign w_sample_last = (r_cnt == CNT_W'(NUM_SAMPLES - 1));
    assign w_final_vec   = (r_idx == '1);

    // Next values of the result registers; score is taken from these so the
    // final sample of the last vector is included when DONE is entered.
    always_comb begin
        w_tt_nxt   = r_tt;
        w_unst_nxt = r_unst;
        if (r_state == S_SAMPLE) begin
            if (r_cnt == '0)
                w_tt_nxt[r_cut_in] = r_sync2;
            else if (r_sync2 != r_tt[r_cut_in])
                w_unst_nxt[r_cut_in] = 1'b1;
        end
        w_match = ~(w_tt_nxt ^ TARGET) & ~w_unst_nxt;
        w_score = '0;
        for (int unsigned i = 0; i < NV; i++)
            w_score = w_score + SW'(w_match[i]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start)
                    w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (w_settle_last)
                    w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (w_sample_last)
                    w_state_nxt = w_final_vec ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_cut_in <= '0;
            r_tt     <= '0;
            r_unst   <= '0;
            r_score  <= '0;
        end else begin
            r_sync1 <= bus.cut_out;
            r_sync2 <= r_sync1;
            case (r_state)
                S_IDLE: begin
                    r_cnt    <= '0;
                    r_cut_in <= '0;
                    if (bus.start) begin
                        r_idx    <= '0;
                        r_cut_in <= vec_of('0);
                        r_tt     <= '0;
                        r_unst   <= '0;
                        r_score  <= '0;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= w_settle_last ? '0 : r_cnt + 1'b1;
                end
                S_SAMPLE: begin
                    r_tt   <= w_tt_nxt;
                    r_unst <= w_unst_nxt;
                    if (w_sample_last) begin
                        r_cnt <= '0;
                        if (w_final_vec) begin
                            r_score <= w_score;
                        end else begin
                            r_idx    <= r_idx + 1'b1;
                            r_cut_in <= vec_of(r_idx + 1'b1);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_cut_in <= '0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.cut_in        = r_cut_in;
    assign bus.busy          = w_busy;
    assign bus.done          = w_done;
    assign bus.result_tt     = r_tt;
    assign bus.unstable_mask = r_unst;
    assign bus.score         = r_score;
endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_truth_table_sweep_ctrl
// Directed bench for truth_table_sweep_ctrl with TARGET = 16'h55AA and a CUT
// model selectable between cut_in[3]^cut_in[0], constant 0, and the xor
// model with an oscillating output while cut_in = 5.
// ---------------------------------------------------------------------------
module tb_truth_table_sweep_ctrl;
    logic clk = 1'b0;
    logic reset;
    logic tog = 1'b0;
    int   mode;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] seq [16];

    truth_table_sweep_ctrl_if #(.IN_WIDTH(4)) bus ();

    truth_table_sweep_ctrl #(
        .IN_WIDTH      (4),
        .SETTLE_CYCLES (8),
        .NUM_SAMPLES   (4),
        .TARGET        (16'h55AA)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    always_comb begin
        bus.cut_out = 1'b0;
        if (mode == 0)
            bus.cut_out = bus.cut_in[3] ^ bus.cut_in[0];
        else if (mode == 2)
            bus.cut_out = (bus.cut_in[3] ^ bus.cut_in[0]) ^ ((bus.cut_in == 4'd5) ? tog : 1'b0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one sweep; returns the cycle (relative to acceptance) at which
    // done was seen. Optionally pulses start at cycle pulse_at while busy.
    task automatic run_sweep(input int pulse_at, output int lat);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 400) begin
            if ((lat - 1) % 12 == 0 && (lat - 1) / 12 < 16)
                seq[(lat - 1) / 12] = bus.cut_in;
            bus.start = (lat == pulse_at);
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int lat, cyc, first, second, n, hd;
        logic [3:0] exp_seq [5];
        logic [3:0] diff;
`ifdef SWEEP_GRAY_EN
        exp_seq = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6};
`else
        exp_seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
`endif
        mode = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_cut_in", 32'(bus.cut_in), 0);
        check("rst_tt", 32'(bus.result_tt), 0);
        check("rst_unst", 32'(bus.unstable_mask), 0);
        check("rst_score", 32'(bus.score), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Test 1: xor model, start pulsed mid-sweep must be ignored.
        run_sweep(100, lat);
        check("t1_latency", 32'(lat), 193);
        check("t1_tt", 32'(bus.result_tt), 32'h55AA);
        check("t1_unst", 32'(bus.unstable_mask), 0);
        check("t1_score", 32'(bus.score), 16);
        check("t1_busy_at_done", 32'(bus.busy), 1);
        for (int k = 0; k < 5; k++)
            check($sformatf("t1_seq%0d", k), 32'(seq[k]), 32'(exp_seq[k]));
`ifdef SWEEP_GRAY_EN
        for (int k = 1; k < 16; k++) begin
            diff = seq[k] ^ seq[k-1];
            hd = 32'(diff[0]) + 32'(diff[1]) + 32'(diff[2]) + 32'(diff[3]);
            check($sformatf("t1_gray_step%0d", k), 32'(hd), 1);
        end
`else
        check("t1_seq15", 32'(seq[15]), 15);
`endif
        @(posedge clk); #1;
        check("t1_busy_after", 32'(bus.busy), 0);
        check("t1_done_after", 32'(bus.done), 0);
        check("t1_cut_in_idle", 32'(bus.cut_in), 0);
        repeat (20) @(posedge clk);
        #1;
        check("t1_no_requeue", 32'(bus.busy), 0);
        check("t1_hold_tt", 32'(bus.result_tt), 32'h55AA);

        // Test 2: output tied low.
        mode = 1;
        run_sweep(0, lat);
        check("t2_latency", 32'(lat), 193);
        check("t2_tt", 32'(bus.result_tt), 0);
        check("t2_unst", 32'(bus.unstable_mask), 0);
        check("t2_score", 32'(bus.score), 8);
        repeat (3) @(posedge clk);
        #1;

        // Test 3: oscillation on vector 5.
        mode = 2;
        run_sweep(0, lat);
        check("t3_latency", 32'(lat), 193);
        check("t3_unst", 32'(bus.unstable_mask), 32'h0020);
        check("t3_score", 32'(bus.score), 15);
        repeat (3) @(posedge clk);
        #1;

        // Test 4: reset at cycle 50 of a sweep.
        mode = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t4_partial_tt", 32'(bus.result_tt), 32'h000A);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_cut_in", 32'(bus.cut_in), 0);
        check("t4_tt", 32'(bus.result_tt), 0);
        check("t4_unst", 32'(bus.unstable_mask), 0);
        check("t4_score", 32'(bus.score), 0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) n++;
            @(posedge clk); #1;
        end
        check("t4_no_done", 32'(n), 0);
        run_sweep(0, lat);
        check("t4_restart_latency", 32'(lat), 193);
        check("t4_restart_tt", 32'(bus.result_tt), 32'h55AA);
        repeat (3) @(posedge clk);
        #1;

        // Test 5: start held high.
        bus.start = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        first = 0;
        second = 0;
        n = 0;
        while (cyc < 400) begin
            if (bus.done) begin
                n++;
                if (first == 0) first = cyc;
                else if (second == 0) second = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check("t5_first_done", 32'(first), 193);
        check("t5_second_done", 32'(second), 387);
        check("t5_done_count", 32'(n), 2);
        n = 0;
        while (bus.busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_returns_idle", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
